// File: rtl/bus_interface_unit_pkg.sv
// -----------------------------------------------------------------------------
// bus_interface_unit_pkg
// Shared definitions for the bus interface unit and the prefetch / execution
// units that talk to it: the arbiter state encoding and the fixed 32-bit
// address/data widths.
// -----------------------------------------------------------------------------
package bus_interface_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Arbiter state encoding, kept as plain constants so that older units
    // comparing raw state codes keep working.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CODE = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    // True while a bus transaction is owned by one of the two ports.
    function automatic logic is_bus_state(input state_t s);
        return (s == ST_CODE) || (s == ST_DATA);
    endfunction

endpackage : bus_interface_unit_pkg

// File: rtl/bus_interface_unit.sv
// -----------------------------------------------------------------------------
// bus_interface_unit
// Two-port arbiter between the CPU code (instruction fetch) port and data
// (load/store) port, forwarding one granted request at a time to the single
// external memory bus. The code port wins when both request in the same idle
// cycle; an owned transaction is never preempted.
//
// Ports
//   i_clock / i_reset          clock, asynchronous active-high reset
//   i_code_* / o_code_*        instruction-fetch request and response
//   i_data_* / o_data_*        load/store request and response
//   o_bus_* / i_bus_*          shared external bus
//
// Completion (ready + read data) is returned combinationally in the same
// cycle the bus raises i_bus_ready; the read value is also captured so each
// *_data_read output keeps the last completed word afterwards.
// -----------------------------------------------------------------------------
module bus_interface_unit
    import bus_interface_unit_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,

    input  logic              i_code_vaild,
    output logic              o_code_ready,
    input  logic [ADDR_W-1:0] i_code_address,
    output logic [DATA_W-1:0] o_code_data_read,

    input  logic              i_data_vaild,
    output logic              o_data_ready,
    input  logic              i_data_write_enable,
    input  logic [ADDR_W-1:0] i_data_address,
    output logic [DATA_W-1:0] o_data_data_read,
    input  logic [DATA_W-1:0] i_data_data_write,

    output logic              o_bus_vaild,
    input  logic              i_bus_ready,
    input  logic              i_bus_busy,
    output logic              o_bus_write_enable,
    output logic [ADDR_W-1:0] o_bus_address,
    input  logic [DATA_W-1:0] i_bus_data_read,
    output logic [DATA_W-1:0] o_bus_data_write
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_grant_code;
    logic                w_grant_data;
    logic                w_code_done;
    logic                w_data_done;

    logic [ADDR_W-1:0]   r_bus_address;
    logic                r_bus_write_enable;
    logic [DATA_W-1:0]   r_bus_data_write;
    logic [DATA_W-1:0]   r_code_hold;
    logic [DATA_W-1:0]   r_data_hold;

    // Arbitration and next-state decision; code has fixed priority over data.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_bus_busy) begin
                    w_state_next = ST_IDLE;
                end else if (i_code_vaild) begin
                    w_state_next = ST_CODE;
                end else if (i_data_vaild) begin
                    w_state_next = ST_DATA;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            // i_bus_busy is ignored once a transaction is owned.
            ST_CODE, ST_DATA: begin
                if (i_bus_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_grant_code = (r_state == ST_IDLE) && (w_state_next == ST_CODE);
    assign w_grant_data = (r_state == ST_IDLE) && (w_state_next == ST_DATA);
    assign w_code_done  = (r_state == ST_CODE) && i_bus_ready;
    assign w_data_done  = (r_state == ST_DATA) && i_bus_ready;

    // Arbiter state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus request registers: loaded on grant, held for the whole transaction.
    // Write enable is dropped on completion so it is only ever high in DATA.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bus_address      <= 32'h0000_0000;
            r_bus_write_enable <= 1'b0;
            r_bus_data_write   <= 32'h0000_0000;
        end else if (w_grant_code) begin
            r_bus_address      <= i_code_address;
            r_bus_write_enable <= 1'b0;
        end else if (w_grant_data) begin
            r_bus_address      <= i_data_address;
            r_bus_write_enable <= i_data_write_enable;
            r_bus_data_write   <= i_data_data_write;
        end else if (w_code_done || w_data_done) begin
            r_bus_write_enable <= 1'b0;
        end
    end

    // Holding registers for the last completed read word of each port.
    // The data-port value is refreshed on writes too (contents don't-care).
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_code_hold <= 32'h0000_0000;
            r_data_hold <= 32'h0000_0000;
        end else begin
            if (w_code_done) begin
                r_code_hold <= i_bus_data_read;
            end
            if (w_data_done) begin
                r_data_hold <= i_bus_data_read;
            end
        end
    end

    assign o_bus_vaild        = is_bus_state(r_state);
    assign o_bus_write_enable = r_bus_write_enable;
    assign o_bus_address      = r_bus_address;
    assign o_bus_data_write   = r_bus_data_write;

    assign o_code_ready     = w_code_done;
    assign o_data_ready     = w_data_done;
    assign o_code_data_read = w_code_done ? i_bus_data_read : r_code_hold;
    assign o_data_data_read = w_data_done ? i_bus_data_read : r_data_hold;

endmodule : bus_interface_unit

// File: tb/tb_bus_interface_unit.sv
// -----------------------------------------------------------------------------
// tb_bus_interface_unit
// Directed, table-driven bench for bus_interface_unit. Each table row is one
// clock cycle: inputs are applied just after the rising edge, outputs are
// compared on the falling edge. Reset behaviour is exercised by hand.
// -----------------------------------------------------------------------------
module tb_bus_interface_unit;

    logic        clk;
    logic        rst;
    logic        code_v;
    logic        code_rdy;
    logic [31:0] code_addr;
    logic [31:0] code_rd;
    logic        data_v;
    logic        data_rdy;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_rd;
    logic [31:0] data_wd;
    logic        bus_v;
    logic        bus_rdy;
    logic        bus_busy;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic [31:0] bus_wd;

    int checks   = 0;
    int failures = 0;

    bus_interface_unit dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_code_vaild        (code_v),
        .o_code_ready        (code_rdy),
        .i_code_address      (code_addr),
        .o_code_data_read    (code_rd),
        .i_data_vaild        (data_v),
        .o_data_ready        (data_rdy),
        .i_data_write_enable (data_we),
        .i_data_address      (data_addr),
        .o_data_data_read    (data_rd),
        .i_data_data_write   (data_wd),
        .o_bus_vaild         (bus_v),
        .i_bus_ready         (bus_rdy),
        .i_bus_busy          (bus_busy),
        .o_bus_write_enable  (bus_we),
        .o_bus_address       (bus_addr),
        .i_bus_data_read     (bus_rdata),
        .o_bus_data_write    (bus_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [31:0] ca;
        logic        dv;
        logic        we;
        logic [31:0] da;
        logic [31:0] dw;
        logic        br;
        logic        bb;
        logic [31:0] brd;
        logic        e_bv;
        logic        e_bwe;
        logic [31:0] e_baddr;
        logic [31:0] e_bwd;
        logic        e_cr;
        logic [31:0] e_cd;
        logic        e_dr;
        logic [31:0] e_dd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic cv, input logic [31:0] ca,
        input logic dv, input logic we, input logic [31:0] da, input logic [31:0] dw,
        input logic br, input logic bb, input logic [31:0] brd,
        input logic e_bv, input logic e_bwe, input logic [31:0] e_baddr, input logic [31:0] e_bwd,
        input logic e_cr, input logic [31:0] e_cd, input logic e_dr, input logic [31:0] e_dd);
        vec_t v;
        v = '{cv, ca, dv, we, da, dw, br, bb, brd,
              e_bv, e_bwe, e_baddr, e_bwd, e_cr, e_cd, e_dr, e_dd};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        code_v    = v.cv;
        code_addr = v.ca;
        data_v    = v.dv;
        data_we   = v.we;
        data_addr = v.da;
        data_wd   = v.dw;
        bus_rdy   = v.br;
        bus_busy  = v.bb;
        bus_rdata = v.brd;
    endtask

    task automatic check_outputs(input int idx, input vec_t v);
        chk("bus_vaild",      idx, {31'd0, bus_v},    {31'd0, v.e_bv});
        chk("bus_we",         idx, {31'd0, bus_we},   {31'd0, v.e_bwe});
        chk("bus_address",    idx, bus_addr,          v.e_baddr);
        chk("bus_data_write", idx, bus_wd,            v.e_bwd);
        chk("code_ready",     idx, {31'd0, code_rdy}, {31'd0, v.e_cr});
        chk("code_data_read", idx, code_rd,           v.e_cd);
        chk("data_ready",     idx, {31'd0, data_rdy}, {31'd0, v.e_dr});
        chk("data_data_read", idx, data_rd,           v.e_dd);
    endtask

    initial begin
        vec_t z;
        // cv ca      dv we da     dw            br bb brd       | bv we baddr  bwd           cr cd  dr dd
        // code fetch alone: granted, 2 wait cycles, completes with 0x1
        add(1, 32'h1,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h0,   32'h0,        0, 32'h1 & 32'h0, 0, 32'h0);
        add(1, 32'h1,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     1, 0, 32'h1,   32'h0,        0, 32'h0, 0, 32'h0);
        add(1, 32'h1,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     1, 0, 32'h1,   32'h0,        0, 32'h0, 0, 32'h0);
        add(1, 32'h1,   0, 0, 32'h0,  32'h0,        1, 0, 32'h1,     1, 0, 32'h1,   32'h0,        1, 32'h1, 0, 32'h0);
        add(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h1,   32'h0,        0, 32'h1, 0, 32'h0);
        // data read alone at 0x20 returning 0x200
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        0, 0, 32'h0,     0, 0, 32'h1,   32'h0,        0, 32'h1, 0, 32'h0);
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        0, 0, 32'h0,     1, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h0);
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        1, 0, 32'h200,   1, 0, 32'h20,  32'h0,        0, 32'h1, 1, 32'h200);
        // bus ready while idle is ignored
        add(0, 32'h0,   0, 0, 32'h0,  32'h0,        1, 0, 32'hFFFF,  0, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h200);
        // simultaneous requests: code first, one idle cycle, then data
        add(1, 32'h1,   1, 0, 32'h20, 32'h0,        0, 0, 32'h0,     0, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h200);
        add(1, 32'h1,   1, 0, 32'h20, 32'h0,        1, 0, 32'h1,     1, 0, 32'h1,   32'h0,        1, 32'h1, 0, 32'h200);
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        0, 0, 32'h0,     0, 0, 32'h1,   32'h0,        0, 32'h1, 0, 32'h200);
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        1, 0, 32'h200,   1, 0, 32'h20,  32'h0,        0, 32'h1, 1, 32'h200);
        add(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h200);
        // code first, data arrives one cycle later: no preemption
        add(1, 32'h1,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h200);
        add(1, 32'h1,   1, 0, 32'h20, 32'h0,        0, 0, 32'h0,     1, 0, 32'h1,   32'h0,        0, 32'h1, 0, 32'h200);
        add(1, 32'h1,   1, 0, 32'h20, 32'h0,        1, 0, 32'h1,     1, 0, 32'h1,   32'h0,        1, 32'h1, 0, 32'h200);
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        0, 0, 32'h0,     0, 0, 32'h1,   32'h0,        0, 32'h1, 0, 32'h200);
        add(0, 32'h0,   1, 0, 32'h20, 32'h0,        1, 0, 32'h200,   1, 0, 32'h20,  32'h0,        0, 32'h1, 1, 32'h200);
        add(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h200);
        // data write 0xDEADBEEF to 0x40
        add(0, 32'h0,   1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0,     0, 0, 32'h20,  32'h0,        0, 32'h1, 0, 32'h200);
        add(0, 32'h0,   1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0,     1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h1, 0, 32'h200);
        add(0, 32'h0,   1, 1, 32'h40, 32'hDEADBEEF, 1, 0, 32'h5555,  1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h1, 1, 32'h5555);
        add(0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h40,  32'hDEADBEEF, 0, 32'h1, 0, 32'h5555);
        // busy holds off the grant; busy is ignored once granted
        add(1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 1, 32'h0,     0, 0, 32'h40,  32'hDEADBEEF, 0, 32'h1, 0, 32'h5555);
        add(1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 1, 32'h0,     0, 0, 32'h40,  32'hDEADBEEF, 0, 32'h1, 0, 32'h5555);
        add(1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,     0, 0, 32'h40,  32'hDEADBEEF, 0, 32'h1, 0, 32'h5555);
        add(1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 1, 32'h0,     1, 0, 32'h100, 32'hDEADBEEF, 0, 32'h1, 0, 32'h5555);

        // reset and check the reset state
        z = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs(-1, z);
        @(posedge clk);
        #1;

        // table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check_outputs(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // DUT is in CODE at 0x100; bus completes just as reset arrives
        code_v    = 1'b1;
        code_addr = 32'h100;
        bus_busy  = 1'b0;
        bus_rdy   = 1'b0;
        bus_rdata = 32'h77;
        #1;
        chk("pre_reset_bus_vaild", 100, {31'd0, bus_v}, 32'd1);
        bus_rdy = 1'b1;
        rst     = 1'b1;
        #1;
        // no clock edge has occurred: everything must already be at reset
        check_outputs(101, z);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        code_v  = 1'b0;
        bus_rdy = 1'b0;
        @(negedge clk);
        check_outputs(102, z);
        // new grant after reset works with one-cycle latency
        @(posedge clk);
        #1;
        code_v    = 1'b1;
        code_addr = 32'hABC0;
        @(negedge clk);
        chk("post_reset_idle_vaild", 103, {31'd0, bus_v}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_reset_grant_vaild", 104, {31'd0, bus_v}, 32'd1);
        chk("post_reset_grant_addr",  104, bus_addr, 32'hABC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        code_v    = 1'b0;
        code_addr = 32'h0;
        data_v    = 1'b0;
        data_we   = 1'b0;
        data_addr = 32'h0;
        data_wd   = 32'h0;
        bus_rdy   = 1'b0;
        bus_busy  = 1'b0;
        bus_rdata = 32'h0;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule : tb_bus_interface_unit
